// File: rtl/mcpu_gen_pkg.sv
// mcpu_gen shared definitions: sequencer state encodings and opcodes.
package mcpu_gen_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'b000,
        STORE = 3'b001,
        ADD   = 3'b010,
        NOR   = 3'b011,
        JNT   = 3'b101,
        HALT  = 3'b111
    } state_e;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_ADD = 2'b01,
        OP_STA = 2'b10,
        OP_JCC = 2'b11
    } opcode_e;

endpackage

// File: rtl/mcpu_gen_if.sv
// mcpu_gen memory bus: unmuxed address/data, write strobe, wait-state ready.
interface mcpu_gen_if #(
    parameter int DW = 8,
    parameter int AW = DW - 2
);
    logic          mem_rdy;
    logic [DW-1:0] data_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          we_o;

    modport master (
        input  mem_rdy,
        input  data_i,
        output addr_o,
        output data_o,
        output we_o
    );

    modport slave (
        output mem_rdy,
        output data_i,
        input  addr_o,
        input  data_o,
        input  we_o
    );
endinterface

// File: rtl/mcpu_gen_alu.sv
// mcpu_gen ALU: combinational NOR/ADD returning {carry,result}.
module mcpu_gen_alu #(
    parameter int DW = 8
) (
    input  logic          add_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW:0]   res_o
);

    always_comb begin
        res_o = {1'b0, ~(a_i | b_i)};
        if (add_i) begin
            res_o = {1'b0, a_i} + {1'b0, b_i};
        end
    end

endmodule

// File: rtl/mcpu_gen.sv
// mcpu_gen: parametrised accumulator CPU (NOR/ADD/STA/JCC) with
// wait states, write strobe and self-loop halt detection.
module mcpu_gen
    import mcpu_gen_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = DW - 2,
    parameter int HALT_DET = 1
) (
    input  logic       clk,
    input  logic       rst,
    mcpu_gen_if.master mem,
    output logic       halted_o,
    output logic [2:0] state_o
);

    state_e        state_q;
    logic [AW-1:0] adreg_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] acc_q;
    logic          carry_q;
    logic          halted_q;
    logic          we_q;

    opcode_e       op;
    logic [AW-1:0] opd;
    logic [DW:0]   alu_res;
    logic          self_loop;

    assign op  = opcode_e'(mem.data_i[DW-1:DW-2]);
    assign opd = mem.data_i[AW-1:0];

    // A taken jump to its own address can never make progress.
    assign self_loop = (HALT_DET != 0) && (opd == adreg_q);

    mcpu_gen_alu #(
        .DW(DW)
    ) u_alu (
        .add_i(state_q == ADD),
        .a_i  (acc_q),
        .b_i  (mem.data_i),
        .res_o(alu_res)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            adreg_q  <= '0;
            pc_q     <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
            we_q     <= 1'b0;
        end else if (state_q != HALT && mem.mem_rdy) begin
            unique case (state_q)
                FETCH: begin
                    pc_q    <= adreg_q + 1'b1;
                    adreg_q <= opd;
                    we_q    <= (op == OP_STA);
                    unique case (op)
                        OP_NOR: state_q <= NOR;
                        OP_ADD: state_q <= ADD;
                        OP_STA: state_q <= STORE;
                        OP_JCC: begin
                            if (carry_q) begin
                                state_q <= JNT;
                            end else if (self_loop) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                        default: state_q <= FETCH;
                    endcase
                end
                STORE, ADD, NOR, JNT: begin
                    adreg_q <= pc_q;
                    state_q <= FETCH;
                    we_q    <= 1'b0;
                    if (state_q == ADD) begin
                        {carry_q, acc_q} <= alu_res;
                    end
                    if (state_q == NOR) begin
                        acc_q <= alu_res[DW-1:0];
                    end
                    if (state_q == JNT) begin
                        carry_q <= 1'b0;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign mem.addr_o = adreg_q;
    assign mem.data_o = acc_q;
    assign mem.we_o   = we_q;
    assign halted_o   = (HALT_DET != 0) ? halted_q : 1'b0;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mcpu_gen.sv
// Self-checking bench for mcpu_gen: instruction-level reference model,
// directed program plus randomized memory/ready/reset traffic.
module tb_mcpu_gen;

    localparam int DW = 8;
    localparam int AW = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       halted;
    logic [2:0] st;

    always #5 clk = ~clk;

    mcpu_gen_if #(.DW(DW), .AW(AW)) bus ();

    mcpu_gen #(
        .DW      (DW),
        .AW      (AW),
        .HALT_DET(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (bus),
        .halted_o(halted),
        .state_o (st)
    );

    logic [7:0] ram [64];
    int         refmem [64];

    assign bus.data_i = ram[bus.addr_o];

    always @(posedge clk) begin
        if (rst && bus.mem_rdy && bus.we_o) ram[bus.addr_o] <= bus.data_o;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: architectural registers plus the phase
    // number the spec assigns to each step of an instruction.
    int m_pc, m_ad, m_acc, m_c, m_st, m_h;

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit d);
        int ins, op, opd, s;
        if (!r) begin
            m_pc = 0; m_ad = 0; m_acc = 0; m_c = 0; m_st = 0; m_h = 0;
        end else if (m_st == 7 || !d) begin
            // frozen or stalled
        end else if (m_st == 0) begin
            ins  = refmem[m_ad];
            op   = ins / 64;
            opd  = ins % 64;
            m_pc = (m_ad + 1) % 64;
            if (op == 3 && m_c == 0 && opd == m_ad) begin
                m_st = 7;
                m_h  = 1;
            end else if (op == 3) begin
                m_st = (m_c != 0) ? 5 : 0;
            end else begin
                m_st = (op == 0) ? 3 : (op == 1) ? 2 : 1;
            end
            m_ad = opd;
        end else begin
            case (m_st)
                3: m_acc = (~(m_acc | refmem[m_ad])) & 255;
                2: begin
                    s     = m_acc + refmem[m_ad];
                    m_acc = s % 256;
                    m_c   = s / 256;
                end
                1: refmem[m_ad] = m_acc;
                5: m_c = 0;
                default: ;
            endcase
            m_ad = m_pc;
            m_st = 0;
        end
    endtask

    task automatic compare_all();
        logic [18:0] act, exp;
        act = {bus.addr_o, bus.data_o, bus.we_o, halted, st};
        exp = {m_ad[5:0], m_acc[7:0], m_st == 1, m_h[0], m_st[2:0]};
        check("cycle addr/data/we/halt/state", int'(act), int'(exp));
    endtask

    task automatic tick(bit r, bit d);
        rst         = r;
        bus.mem_rdy = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic poke(int a, int v);
        ram[a]    = v[7:0];
        refmem[a] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) poke(i, 0);
    endtask

    task automatic check_reset(string nm);
        check(nm, int'({bus.addr_o, bus.data_o, bus.we_o, halted, st}), 0);
    endtask

    initial begin
        bus.mem_rdy = 1'b1;
        clear_mem();
        poke(8'h00, 8'h3F);
        poke(8'h01, 8'h60);
        poke(8'h02, 8'hC5);
        poke(8'h03, 8'hC5);
        poke(8'h05, 8'h21);
        poke(8'h06, 8'h22);
        poke(8'h07, 8'hB0);
        poke(8'h08, 8'hFF);
        poke(8'h3F, 8'h0F);
        poke(8'h20, 8'h20);
        poke(8'h21, 8'hFF);
        poke(8'h22, 8'hA5);

        tick(0, 1);
        check_reset("reset_state");

        tick(1, 1); tick(1, 1);
        check("nor_acc", bus.data_o, 8'hF0);
        check("nor_next_addr", bus.addr_o, 8'h01);
        check("nor_model_carry", m_c, 0);

        tick(1, 1); tick(1, 1);
        check("add_acc", bus.data_o, 8'h10);
        check("add_model_carry", m_c, 1);

        tick(1, 1);
        check("jnt_state", st, 3'b101);
        tick(1, 1);
        check("jnt_next_fetch", bus.addr_o, 8'h03);
        check("jnt_model_carry", m_c, 0);

        tick(1, 1);
        check("jcc_taken_1cyc", int'({bus.addr_o, st}), int'({6'h05, 3'b000}));

        repeat (4) tick(1, 1);
        check("sta_src_acc", bus.data_o, 8'h5A);

        tick(1, 1);
        check("sta_bus", int'({bus.we_o, bus.addr_o, bus.data_o}), int'({1'b1, 6'h30, 8'h5A}));
        for (int i = 0; i < 3; i++) begin
            tick(1, 0);
            check("sta_stall_hold", int'({bus.we_o, bus.addr_o, bus.data_o, st}),
                  int'({1'b1, 6'h30, 8'h5A, 3'b001}));
            check("sta_no_early_write", ram[8'h30], 8'h00);
        end
        tick(1, 1);
        check("sta_release", int'({bus.we_o, bus.addr_o}), int'({1'b0, 6'h08}));
        check("sta_single_write", ram[8'h30], 8'h5A);

        tick(1, 1);
        check("jcc_to_3f", bus.addr_o, 8'h3F);
        tick(1, 1);
        tick(1, 1);
        check("pc_wrap_addr", bus.addr_o, 8'h00);
        check("pc_wrap_acc", bus.data_o, 8'hA5);

        for (int i = 0; i < 200; i++) tick(1, $urandom_range(0, 3) != 0);

        tick(0, 0);
        check_reset("reset_over_stall");

        clear_mem();
        poke(8'h00, 8'hC7);
        poke(8'h07, 8'hC7);
        tick(1, 1);
        check("halt_pre_jump", bus.addr_o, 8'h07);
        tick(1, 1);
        check("halt_entry", int'({halted, st, bus.addr_o}), int'({1'b1, 3'b111, 6'h07}));
        tick(1, 1);
        tick(1, 0);
        tick(1, 1);
        check("halt_frozen", int'({halted, st, bus.addr_o, bus.we_o}),
              int'({1'b1, 3'b111, 6'h07, 1'b0}));
        tick(0, 1);
        check_reset("halt_exit_reset");

        for (int i = 0; i < 64; i++) poke(i, int'($urandom_range(0, 255)));
        tick(0, 1);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 64; i++) check("final_mem", ram[i], refmem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
